// File: rtl/rr_mux_4to1.sv
// Four-channel round-robin merging mux with a single registered output slot.
// Packet mode locks the grant to one channel until its in_last beat passes.
module rr_mux_4to1 #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       in_valid_i,
    input  logic [3:0]       in_last_i,
    input  logic [WIDTH-1:0] in_data0_i,
    input  logic [WIDTH-1:0] in_data1_i,
    input  logic [WIDTH-1:0] in_data2_i,
    input  logic [WIDTH-1:0] in_data3_i,
    output logic [3:0]       in_ready_o,
    output logic             out_valid_o,
    output logic [WIDTH-1:0] out_data_o,
    output logic [1:0]       out_sel_o,
    output logic             out_last_o,
    input  logic             out_ready_i
);

    typedef enum logic {StIdle, StLock} state_e;

    state_e           state_q, state_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [1:0]       owner_q, owner_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [1:0]       out_sel_q, out_sel_d;
    logic             out_last_q, out_last_d;

    logic             can_load;
    logic             grant_found;
    logic [1:0]       grant_idx;
    logic [1:0]       cand;
    logic [3:0]       grant_oh;
    logic             xfer;
    logic [WIDTH-1:0] grant_data;
    logic             grant_last;

    assign can_load = !out_valid_q || out_ready_i;

    // Pick the first valid channel in search order ptr, ptr+1, ... (IDLE) or the owner (LOCK).
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = owner_q;
        cand        = 2'd0;
        if (state_q == StIdle) begin
            for (int k = 0; k < 4; k++) begin
                cand = ptr_q + 2'(k);
                if (!grant_found && in_valid_i[cand]) begin
                    grant_found = 1'b1;
                    grant_idx   = cand;
                end
            end
        end else begin
            grant_found = in_valid_i[owner_q];
        end
        grant_oh = 4'b0000;
        if (can_load && grant_found && !rst) begin
            grant_oh[grant_idx] = 1'b1;
        end
    end

    assign in_ready_o = grant_oh;
    assign xfer       = |grant_oh;
    assign grant_last = in_last_i[grant_idx];

    always_comb begin
        unique case (grant_idx)
            2'd0:    grant_data = in_data0_i;
            2'd1:    grant_data = in_data1_i;
            2'd2:    grant_data = in_data2_i;
            default: grant_data = in_data3_i;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        out_last_d  = out_last_q;
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = grant_data;
            out_sel_d   = grant_idx;
            out_last_d  = grant_last;
            if (grant_last) begin
                ptr_d   = grant_idx + 2'd1;
                state_d = StIdle;
            end else if (state_q == StIdle) begin
                owner_d = grant_idx;
                state_d = StLock;
            end
        end else if (out_ready_i) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            ptr_q       <= 2'd0;
            owner_q     <= 2'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= 2'd0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_sel_o   = out_sel_q;
    assign out_last_o  = out_last_q;

endmodule
